// File: rtl/key_conditioner.sv
// Push-button conditioner for the stopwatch: per-key synchroniser, debounce FSM and
// press/release pulses, plus the derived start/stop toggle and gated clear request.
module key_conditioner #(
  parameter int N_KEYS    = 2,
  parameter int DB_CYCLES = 10000
) (
  input  logic              CLOCK_1,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic              RUN,
  output logic              CLEAR
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_t;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    logic [1:0]       sync_reg;
    key_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;

    // sync_reg[1] is the only stage the FSM looks at; 1 = pressed.
    always_ff @(posedge CLOCK_1) begin
      if (RESET) begin
        sync_reg    <= 2'b00;
        state_reg   <= ST_IDLE;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        sync_reg    <= {sync_reg[0], ~KEY[gi]};
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (sync_reg[1]) begin
              state_reg <= ST_PRESS_WAIT;
              cnt_reg   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!sync_reg[1]) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= ST_PRESSED;
              level_reg <= 1'b1;
              press_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          ST_PRESSED: begin
            if (!sync_reg[1]) begin
              state_reg <= ST_RELEASE_WAIT;
              cnt_reg   <= '0;
            end
          end
          ST_RELEASE_WAIT: begin
            if (sync_reg[1]) begin
              state_reg <= ST_PRESSED;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg   <= ST_IDLE;
              level_reg   <= 1'b0;
              release_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
          end
        endcase
      end
    end

    assign KEY_LEVEL[gi]   = level_reg;
    assign KEY_PRESS[gi]   = press_reg;
    assign KEY_RELEASE[gi] = release_reg;
  end

  logic run_reg;
  logic clear_reg;

  // CLEAR is gated by RUN as it stood before any toggle on this same edge.
  always_ff @(posedge CLOCK_1) begin
    if (RESET) begin
      run_reg   <= 1'b0;
      clear_reg <= 1'b0;
    end else begin
      run_reg   <= run_reg ^ KEY_PRESS[0];
      clear_reg <= KEY_PRESS[1] & ~run_reg;
    end
  end

  assign RUN   = run_reg;
  assign CLEAR = clear_reg;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed latency/gating scenarios followed by random
// bouncing keys, every cycle compared against a run-length debounce model.
module tb_key_conditioner;

  localparam int N  = 3;
  localparam int DB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_drv;
  logic [N-1:0] key_level, key_press, key_release;
  logic         run, clear;

  int n_tests = 0;
  int n_fail  = 0;

  key_conditioner #(.N_KEYS(N), .DB_CYCLES(DB)) dut (
    .CLOCK_1    (clk),
    .RESET      (rst),
    .KEY        (key_drv),
    .KEY_LEVEL  (key_level),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release),
    .RUN        (run),
    .CLEAR      (clear)
  );

  always #5 clk = ~clk;

  // Model: the debounced level flips once the twice-delayed input has disagreed
  // with it on DB+1 consecutive edges.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release;
  logic         m_run, m_clear;
  int           m_len [N];
  int           clear_cnt;
  int           press_cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] obs;
    logic         new_run, new_clear;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
      m_run = 1'b0; m_clear = 1'b0;
      for (int k = 0; k < N; k++) m_len[k] = 0;
    end else begin
      new_run   = m_run ^ m_press[0];
      new_clear = m_press[1] & ~m_run;
      obs  = m_s2;
      m_s2 = m_s1;
      m_s1 = ~key_drv;
      m_press = '0;
      m_release = '0;
      for (int k = 0; k < N; k++) begin
        if (obs[k] != m_level[k]) begin
          m_len[k]++;
          if (m_len[k] == DB + 1) begin
            m_level[k] = ~m_level[k];
            if (m_level[k]) m_press[k] = 1'b1;
            else            m_release[k] = 1'b1;
            m_len[k] = 0;
          end
        end else begin
          m_len[k] = 0;
        end
      end
      m_run   = new_run;
      m_clear = new_clear;
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, compare 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level",   32'(key_level),   32'(m_level));
    check("press",   32'(key_press),   32'(m_press));
    check("release", 32'(key_release), 32'(m_release));
    check("run",     32'(run),         32'(m_run));
    check("clear",   32'(clear),       32'(m_clear));
    if (clear) clear_cnt++;
    for (int k = 0; k < N; k++) if (key_press[k]) press_cnt[k]++;
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int dur [N];
  int first_press;

  initial begin
    rst = 1'b1;
    key_drv = '1;
    clear_cnt = 0;
    for (int k = 0; k < N; k++) begin m_len[k] = 0; press_cnt[k] = 0; end
    @(negedge clk);
    hold(2);
    check("reset_outputs", {key_level, key_press, key_release, run, clear}, 32'd0);
    rst = 1'b0;
    hold(3);

    // Clean press of KEY[0]: pulse only after edge 10, RUN one cycle later.
    key_drv[0] = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      step();
      check("t1_press_timing", 32'(key_press[0]), 32'(i == 10));
      check("t1_level_timing", 32'(key_level[0]), 32'(i == 10));
    end
    step();
    check("t1_run_set", 32'(run), 32'd1);
    hold(5);
    check("t1_no_repeat", 32'(press_cnt[0]), 32'd1);

    // Release of KEY[0]: same timing, RUN unchanged.
    key_drv[0] = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step();
      check("t5_release_timing", 32'(key_release[0]), 32'(i == 10));
    end
    check("t5_level_low", 32'(key_level[0]), 32'd0);
    hold(2);
    check("t5_run_kept", 32'(run), 32'd1);

    // RUN gating: clear ignored while running, honoured once stopped.
    clear_cnt = 0;
    key_drv[1] = 1'b0; hold(14); key_drv[1] = 1'b1; hold(14);
    check("t3_clear_blocked", 32'(clear_cnt), 32'd0);
    key_drv[0] = 1'b0; hold(14); key_drv[0] = 1'b1; hold(14);
    check("t3_run_stopped", 32'(run), 32'd0);
    key_drv[1] = 1'b0; hold(14); key_drv[1] = 1'b1; hold(14);
    check("t3_clear_once", 32'(clear_cnt), 32'd1);

    // Simultaneous press while stopped: CLEAR and RUN rise on the same edge.
    clear_cnt = 0;
    key_drv[1:0] = 2'b00;
    for (int i = 0; i <= 12; i++) begin
      step();
      if (i == 11) begin
        check("t4_clear", 32'(clear), 32'd1);
        check("t4_run",   32'(run),   32'd1);
      end
    end
    key_drv[1:0] = 2'b11;
    hold(14);
    check("t4_clear_once", 32'(clear_cnt), 32'd1);

    // Bounce on KEY[1]: only the final settled low produces a press.
    press_cnt[1] = 0;
    first_press = -1;
    for (int i = 0; i < 24; i++) begin
      key_drv[1] = (i >= 5 && i < 8) ? 1'b1 : 1'b0;
      step();
      if (key_press[1] && first_press < 0) first_press = i;
    end
    check("t2_press_count", 32'(press_cnt[1]), 32'd1);
    check("t2_press_edge",  32'(first_press),  32'd18);
    key_drv[1] = 1'b1;
    hold(14);

    // Reset part-way through a press window: window abandoned, full restart.
    key_drv[0] = 1'b0;
    hold(8);
    rst = 1'b1;
    step();
    check("t6_reset_outputs", {key_level, key_press, key_release, run, clear}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      step();
      check("t6_repress_timing", 32'(key_press[0]), 32'(i == 10));
    end
    key_drv[0] = 1'b1;
    hold(14);

    // Random bouncing on all keys with occasional resets.
    for (int k = 0; k < N; k++) dur[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (dur[k] == 0) begin
          key_drv[k] = 1'($urandom_range(0, 1));
          dur[k] = $urandom_range(1, 14);
        end
        dur[k]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
